i2c_bus_recovery: RTL

I2C_BUS_RECOVERY -- requirements
Module: i2c_bus_recovery

---
 rtl/i2c_rec_pkg.sv | 18 +
 rtl/i2c_in_filter.sv | 44 ++++
 rtl/i2c_bus_recovery.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/i2c_rec_pkg.sv
// Shared defaults and state encoding for the I2C bus-recovery wrapper.
package i2c_rec_pkg;

  localparam int HALF_PERIOD_DEF  = 250;
  localparam int STUCK_CYCLES_DEF = 50000;
  localparam int FILT_LEN_DEF     = 4;
  localparam int MAX_PULSES       = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_STOP_LO,
    ST_STOP_HI,
    ST_STOP_REL
  } rec_state_e;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchronizer followed by a FILT_LEN-sample
// agreement filter; latency from pad to output is 2+FILT_LEN cycles.
module i2c_in_filter
  import i2c_rec_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk_50_max10,
  input  logic fpga_resetn,
  input  logic pad_in,
  output logic filt_out
);

  logic [1:0]          sync_q, sync_d;
  logic [FILT_LEN-2:0] hist_q, hist_d;
  logic                filt_q, filt_d;

  // The live synchronized sample plus FILT_LEN-1 older ones form the window.
  always_comb begin
    sync_d    = {sync_q[0], pad_in};
    hist_d    = hist_q << 1;
    hist_d[0] = sync_q[1];
    filt_d    = filt_q;
    if (sync_q[1] && (&hist_q))
      filt_d = 1'b1;
    else if (!sync_q[1] && !(|hist_q))
      filt_d = 1'b0;
  end

  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) begin
      sync_q <= '1;
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/i2c_bus_recovery.sv
// Sits between an I2C core and its open-drain pads; frees a slave holding SDA
// low by clocking SCL up to MAX_PULSES times and then issuing a STOP.
module i2c_bus_recovery
  import i2c_rec_pkg::*;
#(
  parameter int HALF_PERIOD  = HALF_PERIOD_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF,
  parameter int FILT_LEN     = FILT_LEN_DEF,
  parameter int AUTO_EN      = 1
) (
  input  logic clk_50_max10,
  input  logic fpga_resetn,
  input  logic core_sda_oe,
  input  logic core_scl_oe,
  output logic core_sda_in,
  output logic core_scl_in,
  output logic buf_sda_oe,
  output logic buf_scl_oe,
  input  logic buf_sda_in,
  input  logic buf_scl_in,
  input  logic recover_req,
  output logic busy,
  output logic rec_done,
  output logic rec_fail
);

  localparam int TW = $clog2(HALF_PERIOD + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(HALF_PERIOD - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STUCK_CYCLES);
  localparam logic [3:0]    P_MAX  = 4'(MAX_PULSES);

  rec_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    pulse_q, pulse_d;
  logic          sda_f, scl_f;
  logic          sda_oe, scl_oe, done, fail;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_50_max10 (clk_50_max10),
    .fpga_resetn  (fpga_resetn),
    .pad_in       (buf_sda_in),
    .filt_out     (sda_f)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_50_max10 (clk_50_max10),
    .fpga_resetn  (fpga_resetn),
    .pad_in       (buf_scl_in),
    .filt_out     (scl_f)
  );

  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // cnt_q is the stuck-SDA counter in IDLE and the clock-stretch counter in CLK_HI.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    sda_oe  = 1'b0;
    scl_oe  = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sda_oe = core_sda_oe;
        scl_oe = core_scl_oe;
        if (!sda_f && scl_f && !core_sda_oe) begin
          if (cnt_q != S_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
        if (recover_req || ((AUTO_EN != 0) && (cnt_q == S_MAX))) begin
          state_d = ST_CLK_LO;
          tmr_d   = T_LOAD;
          cnt_d   = '0;
          pulse_d = '0;
        end
      end
      ST_CLK_LO: begin
        scl_oe = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_CLK_HI;
          tmr_d   = T_LOAD;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (!scl_f) begin
          if (cnt_q == S_MAX) begin
            fail    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          pulse_d = pulse_q + 4'd1;
          tmr_d   = T_LOAD;
          if (sda_f) begin
            state_d = ST_STOP_LO;
          end else if (pulse_d < P_MAX) begin
            state_d = ST_CLK_LO;
          end else begin
            fail    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_STOP_LO: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_STOP_HI;
          tmr_d   = T_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_STOP_HI: begin
        sda_oe = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_STOP_REL;
          tmr_d   = T_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_STOP_REL: begin
        if (tmr_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      tmr_d   = '0;
      cnt_d   = '0;
      pulse_d = '0;
    end
  end

  // Gating with reset releases the pads the instant reset asserts.
  assign buf_sda_oe  = fpga_resetn & sda_oe;
  assign buf_scl_oe  = fpga_resetn & scl_oe;
  assign busy        = (state_q != ST_IDLE);
  assign core_sda_in = busy ? 1'b1 : sda_f;
  assign core_scl_in = busy ? 1'b1 : scl_f;
  assign rec_done    = done;
  assign rec_fail    = fail;

endmodule
